hub75_scan: RTL and testbench
=============================

HUB75_SCAN -- requirements
Module: hub75_scan

Interface
REQ-001 SHALL have parameter N_ROWS_MAX, default 64: maximum physical panel rows.
REQ-002 SHALL have parameter N_COLS_MAX, default 256: maximum chained columns.
REQ-003 SHALL have parameter BITDEPTH_MAX, default 8: maximum bits per colour.
REQ-004 SHALL have parameter CTRL_REG_WIDTH, default 32: control input width.
REQ-005 SHALL have parameter MEM_R_ADDR_WIDTH, default $clog2(N_ROWS_MAX*N_COLS_MAX)-1: framebuffer read address width.
REQ-006 SHALL have parameter DEADTIME, default 4: blanking cycles, used only under HUB75_DEADTIME_EN.
REQ-007 Ports: clk  in  1  sole clock; rst_n  in  1  asynchronous active-low reset.
REQ-008 Ports: ctrl_en  in  1  scan enable; ctrl_n_rows, ctrl_n_cols, ctrl_bitdepth, ctrl_base_ticks  in  CTRL_REG_WIDTH  geometry and LSB display time.
REQ-009 Ports: swap_req  in  1  level request to flip buffers; swap_ack  out  1  one-cycle pulse when the flip is taken.
REQ-010 Ports: r_en  out  1; r_addr  out  MEM_R_ADDR_WIDTH; r_bit  out  $clog2(BITDEPTH_MAX); r_buffer  out  1; r_dout  in  6  {R0,G0,B0,R1,G1,B1}; read data is valid exactly one clk after r_en.
REQ-011 Ports: hub_rgb  out  6; hub_clk  out  1; hub_lat  out  1; hub_oe_n  out  1; hub_addr  out  $clog2(N_ROWS_MAX)-1.

Function
REQ-012 States SHALL be IDLE, SHIFT, BLANK, LATCH, DEAD, DISPLAY.
REQ-013 IDLE->SHIFT when ctrl_en=1 and configuration valid: n_rows even, 2..N_ROWS_MAX; n_cols 1..N_COLS_MAX; bitdepth 1..BITDEPTH_MAX; base_ticks>=1. Otherwise remain IDLE.
REQ-014 Control inputs SHALL be shadowed on IDLE->SHIFT and at every frame start; mid-frame changes SHALL have no effect.
REQ-015 Scan order: row 0..n_rows/2-1 outer, bit plane 0..bitdepth-1 inner.
REQ-016 SHIFT: r_addr=row*n_cols+col, r_bit=plane, r_en=1 for one cycle per column; 2 clk per column; hub_rgb SHALL update only while hub_clk=0; hub_clk SHALL rise no earlier than one cycle after an hub_rgb change; exactly n_cols rising edges per SHIFT, which lasts 2*n_cols+2 cycles.
REQ-017 BLANK: hub_oe_n=1 for 1 cycle. LATCH: hub_lat=1 for 1 cycle, hub_addr<=row on the same edge.
REQ-018 DISPLAY: hub_oe_n=0 for exactly ctrl_base_ticks<<plane cycles, then hub_oe_n=1; next plane/row enters SHIFT.
REQ-019 Tick counter SHALL be wide enough for base_ticks<<(BITDEPTH_MAX-1) without wrap.
REQ-020 After the last plane of row n_rows/2-1, the row counter SHALL wrap to 0; if swap_req=1, r_buffer toggles and swap_ack pulses on that same cycle.
REQ-021 swap_req asserted and deasserted mid-frame without reaching a frame end SHALL cause no swap.
REQ-022 ctrl_en=0 in any state SHALL force IDLE on the next edge: hub_oe_n=1, r_en=0, hub_clk=0, hub_lat=0; r_buffer retained.

Reset
REQ-023 On rst_n=0, immediately: state IDLE; hub_oe_n=1; hub_clk, hub_lat, r_en, swap_ack, r_buffer=0; hub_rgb, hub_addr, r_addr, r_bit=0; all counters 0.
REQ-024 Reset mid-DISPLAY SHALL blank the panel asynchronously, without waiting for clk.

Configuration
REQ-025 With HUB75_DEADTIME_EN defined: DEAD state between LATCH and DISPLAY holds hub_oe_n=1 for DEADTIME cycles.
REQ-026 Without HUB75_DEADTIME_EN: LATCH goes directly to DISPLAY; DEAD state and DEADTIME are unused.

Verification
REQ-027 n_rows=4, n_cols=8, bitdepth=2, base_ticks=3 -> per row 8 hub_clk rises per plane; oe_n low 3 then 6 cycles; hub_addr 0,1,0.
REQ-028 Framebuffer model, pixel (row1,col5)=0x3F -> r_addr=13 issued; hub_rgb=0x3F at the 6th hub_clk rise of row 1.
REQ-029 swap_req held high from mid-frame -> exactly one swap_ack, at frame end; r_buffer 0->1; frames before it read buffer 0.
REQ-030 ctrl_bitdepth=0 or n_cols=N_COLS_MAX+1 with ctrl_en=1 -> remains IDLE, r_en never asserted.
REQ-031 rst_n pulled low mid-DISPLAY -> hub_oe_n=1 before the next clk edge; after release, restarts at row 0, plane 0.
REQ-032 HUB75_DEADTIME_EN defined, DEADTIME=4 -> LATCH to oe_n low = 5 cycles; undefined -> 1 cycle.

Source files
------------

// File: rtl/hub75_scan.sv
// hub75_scan: HUB75 LED panel scan controller.
// Reads a double-buffered framebuffer, one column per two clocks. Each bit
// plane is shifted, latched and then shown with binary-weighted on-time.
// Optional build macro HUB75_DEADTIME_EN: inserts a DEAD state that keeps the
// panel blanked for DEADTIME cycles between LATCH and DISPLAY.
module hub75_scan #(
    parameter int N_ROWS_MAX       = 64,
    parameter int N_COLS_MAX       = 256,
    parameter int BITDEPTH_MAX     = 8,
    parameter int CTRL_REG_WIDTH   = 32,
    parameter int MEM_R_ADDR_WIDTH = $clog2(N_ROWS_MAX * N_COLS_MAX) - 1,
    parameter int DEADTIME         = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ctrl_en,
    input  logic [CTRL_REG_WIDTH-1:0]         ctrl_n_rows,
    input  logic [CTRL_REG_WIDTH-1:0]         ctrl_n_cols,
    input  logic [CTRL_REG_WIDTH-1:0]         ctrl_bitdepth,
    input  logic [CTRL_REG_WIDTH-1:0]         ctrl_base_ticks,
    input  logic                              swap_req,
    output logic                              swap_ack,
    output logic                              r_en,
    output logic [MEM_R_ADDR_WIDTH-1:0]       r_addr,
    output logic [$clog2(BITDEPTH_MAX)-1:0]   r_bit,
    output logic                              r_buffer,
    input  logic [5:0]                        r_dout,
    output logic [5:0]                        hub_rgb,
    output logic                              hub_clk,
    output logic                              hub_lat,
    output logic                              hub_oe_n,
    output logic [$clog2(N_ROWS_MAX)-2:0]     hub_addr
);

    localparam int ROW_W   = $clog2(N_ROWS_MAX) - 1;          // row-pair index
    localparam int PLANE_W = $clog2(BITDEPTH_MAX);
    localparam int COL_W   = $clog2(N_COLS_MAX + 1);          // holds N_COLS_MAX itself
    localparam int STEP_W  = COL_W + 1;                       // SHIFT cycle index 0..2n+1
    localparam int TICK_W  = CTRL_REG_WIDTH + BITDEPTH_MAX - 1;
    localparam int AW      = MEM_R_ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DEAD, DISPLAY} state_t;

    state_t                state_reg, state_next;
    logic [STEP_W-1:0]     step_reg, step_next;
    logic [PLANE_W-1:0]    plane_reg, plane_next;
    logic [ROW_W-1:0]      row_reg, row_next;
    logic [AW-1:0]         row_base_reg, row_base_next;
    logic [TICK_W-1:0]     tick_reg, tick_next;
    logic                  buffer_reg, buffer_next;

    // Shadowed geometry, stable for a whole frame
    logic [ROW_W-1:0]      last_row_reg, last_row_next;
    logic [COL_W-1:0]      n_cols_reg, n_cols_next;
    logic [PLANE_W-1:0]    last_plane_reg, last_plane_next;
    logic [CTRL_REG_WIDTH-1:0] base_reg, base_next;

    // Registered panel / memory outputs, decoded from the next state
    logic                  r_en_next, hub_clk_next, hub_lat_next, hub_oe_n_next, swap_ack_next;
    logic [AW-1:0]         r_addr_next;
    logic [PLANE_W-1:0]    r_bit_next;
    logic [5:0]            hub_rgb_next;
    logic [ROW_W-1:0]      hub_addr_next;

    logic                  cfg_ok, load_cfg, swap;
    logic [COL_W-1:0]      col_next;
    logic [TICK_W-1:0]     disp_m1;

    assign cfg_ok = (ctrl_n_rows[0] == 1'b0)
                 && (ctrl_n_rows >= CTRL_REG_WIDTH'(2))
                 && (ctrl_n_rows <= CTRL_REG_WIDTH'(N_ROWS_MAX))
                 && (ctrl_n_cols >= CTRL_REG_WIDTH'(1))
                 && (ctrl_n_cols <= CTRL_REG_WIDTH'(N_COLS_MAX))
                 && (ctrl_bitdepth >= CTRL_REG_WIDTH'(1))
                 && (ctrl_bitdepth <= CTRL_REG_WIDTH'(BITDEPTH_MAX))
                 && (ctrl_base_ticks >= CTRL_REG_WIDTH'(1));

    // On-time of the current plane minus one (tick counter counts down to 0)
    assign disp_m1 = (TICK_W'(base_reg) << plane_reg) - TICK_W'(1);

    // Next-state, counter and output decode
    always_comb begin
        state_next    = state_reg;
        step_next     = step_reg;
        plane_next    = plane_reg;
        row_next      = row_reg;
        row_base_next = row_base_reg;
        tick_next     = tick_reg;
        load_cfg      = 1'b0;
        swap          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (ctrl_en && cfg_ok) begin
                    load_cfg      = 1'b1;
                    state_next    = SHIFT;
                    step_next     = '0;
                    plane_next    = '0;
                    row_next      = '0;
                    row_base_next = '0;
                end
            end
            SHIFT: begin
                if (step_reg == {n_cols_reg, 1'b1}) begin
                    state_next = BLANK;
                    step_next  = '0;
                end else begin
                    step_next = step_reg + STEP_W'(1);
                end
            end
            BLANK: state_next = LATCH;
            LATCH: begin
`ifdef HUB75_DEADTIME_EN
                state_next = DEAD;
                tick_next  = TICK_W'(DEADTIME - 1);
`else
                state_next = DISPLAY;
                tick_next  = disp_m1;
`endif
            end
            DEAD: begin
                if (tick_reg == '0) begin
                    state_next = DISPLAY;
                    tick_next  = disp_m1;
                end else begin
                    tick_next = tick_reg - TICK_W'(1);
                end
            end
            DISPLAY: begin
                if (tick_reg != '0) begin
                    tick_next = tick_reg - TICK_W'(1);
                end else begin
                    state_next = SHIFT;
                    step_next  = '0;
                    if (plane_reg != last_plane_reg) begin
                        plane_next = plane_reg + PLANE_W'(1);
                    end else begin
                        plane_next = '0;
                        if (row_reg != last_row_reg) begin
                            row_next      = row_reg + ROW_W'(1);
                            row_base_next = row_base_reg + AW'(n_cols_reg);
                        end else begin
                            // Frame end: wrap, flip buffers on request, re-shadow controls
                            row_next      = '0;
                            row_base_next = '0;
                            swap          = swap_req;
                            if (cfg_ok) load_cfg = 1'b1;
                            else        state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (!ctrl_en) begin
            state_next = IDLE;
            load_cfg   = 1'b0;
            swap       = 1'b0;
        end

        last_row_next   = load_cfg ? ROW_W'(ctrl_n_rows >> 1) - ROW_W'(1) : last_row_reg;
        n_cols_next     = load_cfg ? COL_W'(ctrl_n_cols) : n_cols_reg;
        last_plane_next = load_cfg ? PLANE_W'(ctrl_bitdepth) - PLANE_W'(1) : last_plane_reg;
        base_next       = load_cfg ? ctrl_base_ticks : base_reg;
        buffer_next     = buffer_reg ^ swap;
        swap_ack_next   = swap;

        // Even SHIFT steps issue a read; odd steps from 3 on hold hub_clk high,
        // one cycle after the matching pixel was placed on hub_rgb.
        col_next      = step_next[STEP_W-1:1];
        r_en_next     = (state_next == SHIFT) && !step_next[0]
                     && ((step_next == '0) || (col_next < n_cols_reg));
        r_addr_next   = r_en_next ? row_base_next + AW'(col_next) : r_addr;
        r_bit_next    = plane_next;
        hub_clk_next  = (state_next == SHIFT) && step_next[0] && (step_next >= STEP_W'(3));
        hub_lat_next  = (state_next == LATCH);
        hub_addr_next = (state_next == LATCH) ? row_reg : hub_addr;
        hub_oe_n_next = (state_next != DISPLAY);
        hub_rgb_next  = ((state_reg == SHIFT) && step_reg[0] && (step_reg < {n_cols_reg, 1'b0}))
                      ? r_dout : hub_rgb;
    end

    // State, counters, shadows and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            step_reg       <= '0;
            plane_reg      <= '0;
            row_reg        <= '0;
            row_base_reg   <= '0;
            tick_reg       <= '0;
            buffer_reg     <= 1'b0;
            last_row_reg   <= '0;
            n_cols_reg     <= '0;
            last_plane_reg <= '0;
            base_reg       <= '0;
            swap_ack       <= 1'b0;
            r_en           <= 1'b0;
            r_addr         <= '0;
            r_bit          <= '0;
            hub_rgb        <= '0;
            hub_clk        <= 1'b0;
            hub_lat        <= 1'b0;
            hub_oe_n       <= 1'b1;
            hub_addr       <= '0;
        end else begin
            state_reg      <= state_next;
            step_reg       <= step_next;
            plane_reg      <= plane_next;
            row_reg        <= row_next;
            row_base_reg   <= row_base_next;
            tick_reg       <= tick_next;
            buffer_reg     <= buffer_next;
            last_row_reg   <= last_row_next;
            n_cols_reg     <= n_cols_next;
            last_plane_reg <= last_plane_next;
            base_reg       <= base_next;
            swap_ack       <= swap_ack_next;
            r_en           <= r_en_next;
            r_addr         <= r_addr_next;
            r_bit          <= r_bit_next;
            hub_rgb        <= hub_rgb_next;
            hub_clk        <= hub_clk_next;
            hub_lat        <= hub_lat_next;
            hub_oe_n       <= hub_oe_n_next;
            hub_addr       <= hub_addr_next;
        end
    end

    assign r_buffer = buffer_reg;

endmodule

// File: tb/tb_hub75_scan.sv
// tb_hub75_scan: directed bench for hub75_scan with a framebuffer model.
module tb_hub75_scan;

`ifdef HUB75_DEADTIME_EN
    localparam int DEAD_CYC = 4;
`else
    localparam int DEAD_CYC = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ctrl_en;
    logic [31:0] ctrl_n_rows, ctrl_n_cols, ctrl_bitdepth, ctrl_base_ticks;
    logic        swap_req, swap_ack;
    logic        r_en, r_buffer;
    logic [12:0] r_addr;
    logic [2:0]  r_bit;
    logic [5:0]  r_dout = 6'h0;
    logic [5:0]  hub_rgb;
    logic        hub_clk, hub_lat, hub_oe_n;
    logic [4:0]  hub_addr;

    hub75_scan dut (
        .clk(clk), .rst_n(rst_n), .ctrl_en(ctrl_en),
        .ctrl_n_rows(ctrl_n_rows), .ctrl_n_cols(ctrl_n_cols),
        .ctrl_bitdepth(ctrl_bitdepth), .ctrl_base_ticks(ctrl_base_ticks),
        .swap_req(swap_req), .swap_ack(swap_ack),
        .r_en(r_en), .r_addr(r_addr), .r_bit(r_bit), .r_buffer(r_buffer), .r_dout(r_dout),
        .hub_rgb(hub_rgb), .hub_clk(hub_clk), .hub_lat(hub_lat),
        .hub_oe_n(hub_oe_n), .hub_addr(hub_addr)
    );

    always #5 clk = ~clk;

    // Pixel content; (row1,col5) = address 13 is full white in every plane/buffer
    function automatic logic [5:0] pix(input logic b, input logic [12:0] a, input logic [2:0] bt);
        int v;
        if (a == 13'd13) return 6'h3F;
        v = int'(a) * 5 + int'(bt) * 11 + (b ? 23 : 0);
        return v[5:0];
    endfunction

    // Framebuffer: data valid one clock after r_en
    always @(posedge clk) if (r_en) r_dout <= pix(r_buffer, r_addr, r_bit);

    int vectors = 0, miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("  ok   %s = %0d", tag, got);
        end
    endtask

    // Monitor state, updated once per clock by step()
    int cyc, lat_cnt, oe_run_cnt, cur_run, lat_cyc_last, ack_cnt, ack_cyc, ren_total;
    int rd_buf1_pre, rd_buf0_post, addr_err, rgb_err, stab_err;
    int seg_rises[16], oe_runs[16], oe_rise_cyc[16], lat_addr[16], lat_cyc[16];
    int lat_to_oe[16], ren_cnt_seg[16], first_ren_cyc[16];
    bit waiting_oe, seen13;
    logic [5:0] rgb6_seg2, prev_rgb;
    logic prev_clk, prev_oe;
    logic [5:0] exp_q[$];

    task automatic clear();
        cyc = 0; lat_cnt = 0; oe_run_cnt = 0; cur_run = 0; lat_cyc_last = 0;
        ack_cnt = 0; ack_cyc = -1; ren_total = 0; rd_buf1_pre = 0; rd_buf0_post = 0;
        addr_err = 0; rgb_err = 0; stab_err = 0; waiting_oe = 0; seen13 = 0;
        rgb6_seg2 = 6'h0; prev_rgb = hub_rgb; prev_clk = hub_clk; prev_oe = hub_oe_n;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            seg_rises[i] = 0; oe_runs[i] = 0; oe_rise_cyc[i] = 0; lat_addr[i] = 0;
            lat_cyc[i] = 0; lat_to_oe[i] = 0; ren_cnt_seg[i] = 0; first_ren_cyc[i] = 0;
        end
    endtask

    // Advance one clock and record panel/memory activity (sampled at negedge)
    task automatic step();
        int seg;
        @(negedge clk);
        cyc++;
        seg = lat_cnt;
        if (swap_ack) begin ack_cnt++; ack_cyc = cyc; end
        if (r_en) begin
            ren_total++;
            if (seg < 16) begin
                if (ren_cnt_seg[seg] == 0) first_ren_cyc[seg] = cyc;
                if (int'(r_addr) != ((seg / 2) % 2) * 8 + ren_cnt_seg[seg] || int'(r_bit) != seg % 2)
                    addr_err++;
                ren_cnt_seg[seg]++;
            end
            if (r_addr == 13'd13) seen13 = 1;
            exp_q.push_back(pix(r_buffer, r_addr, r_bit));
            if (ack_cnt == 0 && r_buffer) rd_buf1_pre++;
            if (ack_cnt > 0 && !r_buffer) rd_buf0_post++;
        end
        if (hub_clk && !prev_clk) begin
            if (seg < 16) seg_rises[seg]++;
            if (exp_q.size() == 0) rgb_err++;
            else if (hub_rgb != exp_q.pop_front()) rgb_err++;
            if (seg == 2 && seg_rises[2] == 6) rgb6_seg2 = hub_rgb;
        end
        if (hub_rgb != prev_rgb && hub_clk) stab_err++;
        if (hub_lat) begin
            if (lat_cnt < 16) begin lat_addr[lat_cnt] = int'(hub_addr); lat_cyc[lat_cnt] = cyc; end
            lat_cyc_last = cyc; waiting_oe = 1; lat_cnt++;
        end
        if (!hub_oe_n) begin
            cur_run++;
            if (waiting_oe && lat_cnt > 0 && lat_cnt <= 16) lat_to_oe[lat_cnt-1] = cyc - lat_cyc_last;
            waiting_oe = 0;
        end
        if (hub_oe_n && !prev_oe) begin
            if (oe_run_cnt < 16) begin oe_runs[oe_run_cnt] = cur_run; oe_rise_cyc[oe_run_cnt] = cyc; end
            oe_run_cnt++; cur_run = 0;
        end
        prev_rgb = hub_rgb; prev_clk = hub_clk; prev_oe = hub_oe_n;
    endtask

    bit pulse_done, held;
    int pulse_left;
    int exp_oe[5]   = '{3, 6, 3, 6, 5};
    int exp_addr[6] = '{0, 0, 1, 1, 0, 0};

    initial begin
        rst_n = 1'b0; ctrl_en = 1'b0; swap_req = 1'b0;
        ctrl_n_rows = 4; ctrl_n_cols = 8; ctrl_bitdepth = 2; ctrl_base_ticks = 3;
        repeat (2) @(negedge clk);
        // Reset state
        check("rst_oe_n", hub_oe_n, 1);   check("rst_hub_clk", hub_clk, 0);
        check("rst_lat", hub_lat, 0);     check("rst_r_en", r_en, 0);
        check("rst_ack", swap_ack, 0);    check("rst_buffer", r_buffer, 0);
        check("rst_rgb", hub_rgb, 0);     check("rst_hub_addr", hub_addr, 0);
        check("rst_r_addr", r_addr, 0);   check("rst_r_bit", r_bit, 0);
        rst_n = 1'b1;

        // Invalid configurations stay in IDLE
        clear(); ctrl_bitdepth = 0; ctrl_en = 1'b1;
        repeat (40) step();
        check("bd0_r_en_cnt", ren_total, 0); check("bd0_oe_low", cur_run + oe_run_cnt, 0);
        ctrl_en = 1'b0; step();
        clear(); ctrl_bitdepth = 2; ctrl_n_cols = 257; ctrl_en = 1'b1;
        repeat (40) step();
        check("c257_r_en_cnt", ren_total, 0); check("c257_oe_low", cur_run + oe_run_cnt, 0);

        // Normal scan 4x8, 2 planes, base 3; swap pulse mid-frame, then held request
        clear(); ctrl_n_cols = 8;
        pulse_done = 0; held = 0; pulse_left = 0;
        for (int i = 0; i < 1000 && lat_cnt < 6; i++) begin
            step();
            if (lat_cnt == 1 && !pulse_done) begin
                swap_req = 1'b1; ctrl_base_ticks = 5; pulse_done = 1; pulse_left = 4;
            end else if (pulse_left > 0) begin
                pulse_left--;
                if (pulse_left == 0) swap_req = 1'b0;
            end
            if (lat_cnt == 3 && !held) begin swap_req = 1'b1; held = 1; end
            if (ack_cnt > 0) swap_req = 1'b0;
        end
        check("latch_wait", lat_cnt >= 6, 1);
        for (int i = 0; i < 6; i++) check($sformatf("rises_seg%0d", i), seg_rises[i], 8);
        for (int i = 0; i < 5; i++) check($sformatf("oe_run%0d", i), oe_runs[i], exp_oe[i]);
        for (int i = 0; i < 6; i++) check($sformatf("lat_addr%0d", i), lat_addr[i], exp_addr[i]);
        check("lat_to_oe", lat_to_oe[0], 1 + DEAD_CYC);
        check("frame_period", lat_cyc[4] - lat_cyc[0], 98 + 4 * DEAD_CYC);
        check("shift_to_latch", lat_cyc[1] - first_ren_cyc[1], 19);
        check("addr13_seen", seen13, 1);
        check("rgb_r1c5", rgb6_seg2, 6'h3F);
        check("rgb_stream_err", rgb_err, 0);
        check("addr_seq_err", addr_err, 0);
        check("rgb_stable_err", stab_err, 0);
        check("ack_count", ack_cnt, 1);
        check("ack_at_frame_end", ack_cyc, oe_rise_cyc[3]);
        check("buf1_before_ack", rd_buf1_pre, 0);
        check("buf0_after_ack", rd_buf0_post, 0);
        check("buffer_now", r_buffer, 1);

        // ctrl_en dropped during DISPLAY
        for (int i = 0; i < 300 && hub_oe_n; i++) step();
        check("disp_wait", hub_oe_n, 0);
        ctrl_en = 1'b0;
        step();
        check("off_oe_n", hub_oe_n, 1); check("off_r_en", r_en, 0);
        check("off_hub_clk", hub_clk, 0); check("off_lat", hub_lat, 0);
        check("off_buffer", r_buffer, 1);
        clear(); repeat (30) step();
        check("off_r_en_cnt", ren_total, 0);

        // Asynchronous reset in DISPLAY
        ctrl_base_ticks = 3; ctrl_en = 1'b1; clear();
        for (int i = 0; i < 300 && hub_oe_n; i++) step();
        check("disp_wait2", hub_oe_n, 0);
        #2 rst_n = 1'b0;
        #1 check("async_blank", hub_oe_n, 1);
        check("async_buffer", r_buffer, 0);
        step(); step();
        rst_n = 1'b1;
        clear();
        for (int i = 0; i < 10 && !r_en; i++) step();
        check("restart_r_en", r_en, 1);
        check("restart_addr", r_addr, 0);
        check("restart_bit", r_bit, 0);
        for (int i = 0; i < 100 && !hub_lat; i++) step();
        check("restart_lat", hub_lat, 1);
        check("restart_row", hub_addr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
